// File: rtl/circular_shift_register_pkg.sv
// Shared constants for the sequential building blocks.
//   ROT_LEFT / ROT_RIGHT : rotation direction selectors for DIR parameters.
//   DEFAULT_WIDTH        : default register width.
package circular_shift_register_pkg;

  localparam int ROT_LEFT      = 0;
  localparam int ROT_RIGHT     = 1;
  localparam int DEFAULT_WIDTH = 4;

endpackage : circular_shift_register_pkg

// File: rtl/circular_shift_register.sv
// WIDTH-bit ring shift register. The word rotates by one position on every
// rising clock edge. The bit that wraps around is XORed with the serial inject
// bit d. With d=0 the block is a pure rotator, for example a one-hot ring
// counter. With d=1 the wrapped bit is toggled, which adds or removes a token.
//
// Ports:
//   clk : clock; all state updates on the rising edge
//   rst : asynchronous, active-low reset; loads RESET_VALUE
//   d   : serial inject bit, XORed into the wrapped bit
//   q   : register contents, driven directly from flops
module circular_shift_register
  import circular_shift_register_pkg::*;
#(
  parameter int               WIDTH       = DEFAULT_WIDTH,
  parameter logic [WIDTH-1:0] RESET_VALUE = {{(WIDTH-1){1'b0}}, 1'b1},
  parameter int               DIR         = ROT_LEFT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             d,
  output logic [WIDTH-1:0] q
);

  if (WIDTH < 2) begin : g_bad_width
    $fatal(1, "circular_shift_register: WIDTH must be >= 2");
  end

  if ((DIR != ROT_LEFT) && (DIR != ROT_RIGHT)) begin : g_bad_dir
    $fatal(1, "circular_shift_register: DIR must be 0 (left) or 1 (right)");
  end

  logic [WIDTH-1:0] q_next;

  // Left rotation moves the MSB into the LSB. Right rotation moves the LSB
  // into the MSB. In both cases d is XORed only into the bit that wraps.
  if (DIR == ROT_LEFT) begin : g_left
    assign q_next = {q[WIDTH-2:0], q[WIDTH-1] ^ d};
  end else begin : g_right
    assign q_next = {q[0] ^ d, q[WIDTH-1:1]};
  end

  // Ring register stage
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) q <= RESET_VALUE;
    else      q <= q_next;
  end

endmodule : circular_shift_register

// File: tb/tb_circular_shift_register.sv
module tb_circular_shift_register;

  logic       clk;
  logic       rst_l, d_l;
  logic       rst_r, d_r;
  logic [3:0] q_l, q_r;

  int vectors;
  int miscompares;

  circular_shift_register #(.WIDTH(4), .RESET_VALUE(4'b0001), .DIR(0)) dut_left (
    .clk (clk),
    .rst (rst_l),
    .d   (d_l),
    .q   (q_l)
  );

  circular_shift_register #(.WIDTH(4), .RESET_VALUE(4'b0001), .DIR(1)) dut_right (
    .clk (clk),
    .rst (rst_r),
    .d   (d_r),
    .q   (q_r)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one rising edge, then settle away from it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    // Assert reset at t=2, before the first rising edge at t=5.
    #2;
    rst_l = 1'b0;
    rst_r = 1'b0;
    d_l   = 1'b0;
    d_r   = 1'b0;
    #1;
    vectors++;
    if (q_l !== 4'b0001) begin
      miscompares++;
      $display("FAIL reset_async_left: got %b expected %b", q_l, 4'b0001);
    end
    vectors++;
    if (q_r !== 4'b0001) begin
      miscompares++;
      $display("FAIL reset_async_right: got %b expected %b", q_r, 4'b0001);
    end
    d_l = 1'b1;
    d_r = 1'b1;
    for (int i = 0; i < 2; i++) begin
      step();
      vectors++;
      if (q_l !== 4'b0001) begin
        miscompares++;
        $display("FAIL reset_hold_left[%0d]: got %b expected %b", i, q_l, 4'b0001);
      end
    end
    d_l = 1'b0;
    d_r = 1'b0;
  endtask

  task automatic test_rotate_left();
    logic [3:0] exp [8];
    exp = '{4'b0010, 4'b0100, 4'b1000, 4'b0001,
            4'b0010, 4'b0100, 4'b1000, 4'b0001};
    rst_l = 1'b1;
    for (int i = 0; i < 8; i++) begin
      step();
      vectors++;
      if (q_l !== exp[i]) begin
        miscompares++;
        $display("FAIL rotate_left[%0d]: got %b expected %b", i, q_l, exp[i]);
      end
    end
  endtask

  task automatic test_inject();
    logic [3:0] exp [3];
    exp = '{4'b0110, 4'b1100, 4'b1001};
    // q is 0001 here. Injecting 1 at the wrap turns the MSB 0 into an LSB 1.
    d_l = 1'b1;
    step();
    vectors++;
    if (q_l !== 4'b0011) begin
      miscompares++;
      $display("FAIL inject_add: got %b expected %b", q_l, 4'b0011);
    end
    d_l = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      vectors++;
      if (q_l !== exp[i]) begin
        miscompares++;
        $display("FAIL inject_follow[%0d]: got %b expected %b", i, q_l, exp[i]);
      end
    end
  endtask

  task automatic test_mid_reset();
    // Return to 0001 with reset, then rotate twice to reach 0100.
    rst_l = 1'b0;
    #1;
    rst_l = 1'b1;
    step();
    step();
    vectors++;
    if (q_l !== 4'b0100) begin
      miscompares++;
      $display("FAIL mid_reset_setup: got %b expected %b", q_l, 4'b0100);
    end
    // Pulse reset between edges.
    rst_l = 1'b0;
    #1;
    vectors++;
    if (q_l !== 4'b0001) begin
      miscompares++;
      $display("FAIL mid_reset_async: got %b expected %b", q_l, 4'b0001);
    end
    rst_l = 1'b1;
    step();
    vectors++;
    if (q_l !== 4'b0010) begin
      miscompares++;
      $display("FAIL mid_reset_restart: got %b expected %b", q_l, 4'b0010);
    end
  endtask

  task automatic test_zero_state();
    // From 0010: 0100, then 1000.
    step();
    step();
    vectors++;
    if (q_l !== 4'b1000) begin
      miscompares++;
      $display("FAIL zero_setup: got %b expected %b", q_l, 4'b1000);
    end
    d_l = 1'b1;
    step();
    vectors++;
    if (q_l !== 4'b0000) begin
      miscompares++;
      $display("FAIL zero_remove_token: got %b expected %b", q_l, 4'b0000);
    end
    d_l = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step();
      vectors++;
      if (q_l !== 4'b0000) begin
        miscompares++;
        $display("FAIL zero_fixed_point[%0d]: got %b expected %b", i, q_l, 4'b0000);
      end
    end
  endtask

  task automatic test_rotate_right();
    logic [3:0] exp [4];
    exp = '{4'b1000, 4'b0100, 4'b0010, 4'b0001};
    // The right-hand instance has been held in reset the whole time.
    vectors++;
    if (q_r !== 4'b0001) begin
      miscompares++;
      $display("FAIL right_held_reset: got %b expected %b", q_r, 4'b0001);
    end
    rst_r = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      vectors++;
      if (q_r !== exp[i]) begin
        miscompares++;
        $display("FAIL rotate_right[%0d]: got %b expected %b", i, q_r, exp[i]);
      end
    end
    // At 0001, injecting 1 cancels the LSB as it wraps into the MSB.
    d_r = 1'b1;
    step();
    vectors++;
    if (q_r !== 4'b0000) begin
      miscompares++;
      $display("FAIL right_inject_remove: got %b expected %b", q_r, 4'b0000);
    end
    // From 0000, injecting 1 adds a token at the MSB.
    step();
    vectors++;
    if (q_r !== 4'b1000) begin
      miscompares++;
      $display("FAIL right_inject_add: got %b expected %b", q_r, 4'b1000);
    end
    d_r = 1'b0;
    step();
    vectors++;
    if (q_r !== 4'b0100) begin
      miscompares++;
      $display("FAIL right_after_inject: got %b expected %b", q_r, 4'b0100);
    end
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    rst_l = 1'b1;
    rst_r = 1'b1;
    d_l   = 1'b0;
    d_r   = 1'b0;
    test_reset();
    test_rotate_left();
    test_inject();
    test_mid_reset();
    test_zero_state();
    test_rotate_right();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule : tb_circular_shift_register
